// File: rtl/mmio_io_pkg.sv
// ============================================================================
// Module      : mmio_io_pkg
// Description : Register offsets and sizes shared by the MMIO I/O controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_io_pkg;

  localparam logic [2:0] OFF_IN_DATA  = 3'd0;
  localparam logic [2:0] OFF_OUT_DATA = 3'd1;
  localparam logic [2:0] OFF_OUT_SET  = 3'd2;
  localparam logic [2:0] OFF_OUT_CLR  = 3'd3;
  localparam logic [2:0] OFF_IN_CHG   = 3'd4;
  localparam logic [2:0] OFF_IRQ_MASK = 3'd5;

  localparam int unsigned NUM_REGS = 6;

endpackage

`default_nettype wire

// File: rtl/mmio_io_ctrl_io_debouncer.sv
// ============================================================================
// Module      : io_debouncer
// Description : Per-bit synchroniser plus tick-sampled two-sample debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_debouncer #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] deb,
  output logic [WIDTH-1:0] deb_changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt;

  logic             w_tick;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_agree;
  logic [WIDTH-1:0] w_deb_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_cnt == c_cnt_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  // A bit only moves when two consecutive tick samples agree.
  assign w_agree    = ~(w_sync ^ r_prev);
  assign w_deb_next = w_tick ? ((w_sync & w_agree) | (r_deb & ~w_agree)) : r_deb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
      r_deb  <= '0;
    end else begin
      if (w_tick) r_prev <= w_sync;
      r_deb <= w_deb_next;
    end
  end

  assign deb         = r_deb;
  assign deb_changed = w_deb_next ^ r_deb;

endmodule

`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
// ============================================================================
// Module      : mmio_io_ctrl
// Description : Relocatable MMIO window for debounced inputs, outputs and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'd4096,
  parameter int          IN_WIDTH        = 16,
  parameter int          OUT_WIDTH       = 16,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 wren,
  output logic [31:0]          rdata,
  output logic                 sel,
  input  logic [IN_WIDTH-1:0]  in_raw,
  output logic [OUT_WIDTH-1:0] out_q,
  output logic                 irq
);

  localparam logic [31:0] c_last_addr = BASE_ADDR + 32'(NUM_REGS - 1);

  logic [OUT_WIDTH-1:0] r_out;
  logic [IN_WIDTH-1:0]  r_chg;
  logic [IN_WIDTH-1:0]  r_mask;

  logic [IN_WIDTH-1:0]  w_deb;
  logic [IN_WIDTH-1:0]  w_deb_changed;
  logic [2:0]           w_off;
  logic                 w_wr;
  logic [OUT_WIDTH-1:0] w_wd_out;
  logic [IN_WIDTH-1:0]  w_wd_in;
  logic [IN_WIDTH-1:0]  w_chg_clr;
  logic [31:0]          w_rdata;

  io_debouncer #(
    .WIDTH           (IN_WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_raw      (in_raw),
    .deb         (w_deb),
    .deb_changed (w_deb_changed)
  );

  assign sel = (addr >= BASE_ADDR) && (addr <= c_last_addr);
  // Window spans fewer than 8 words, so the low 3 bits of the difference suffice.
  assign w_off    = addr[2:0] - BASE_ADDR[2:0];
  assign w_wr     = wren && sel;
  assign w_wd_out = wdata[OUT_WIDTH-1:0];
  assign w_wd_in  = wdata[IN_WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_OUT_DATA: r_out <= w_wd_out;
        OFF_OUT_SET:  r_out <= r_out | w_wd_out;
        OFF_OUT_CLR:  r_out <= r_out & ~w_wd_out;
        default:      r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_mask <= '0;
    else if (w_wr && (w_off == OFF_IRQ_MASK)) r_mask <= w_wd_in;
  end

  assign w_chg_clr = (w_wr && (w_off == OFF_IN_CHG)) ? w_wd_in : '0;

  // New change events are OR-ed in after the clear so a coincident set survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_chg <= '0;
    else r_chg <= (r_chg & ~w_chg_clr) | w_deb_changed;
  end

  always_comb begin
    w_rdata = '0;
    if (sel) begin
      case (w_off)
        OFF_IN_DATA:  w_rdata = 32'(w_deb);
        OFF_OUT_DATA: w_rdata = 32'(r_out);
        OFF_IN_CHG:   w_rdata = 32'(r_chg);
        OFF_IRQ_MASK: w_rdata = 32'(r_mask);
        default:      w_rdata = '0;
      endcase
    end
  end

  assign rdata = w_rdata;
  assign out_q = r_out;
  assign irq   = |(r_chg & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
// ============================================================================
// Module      : tb_mmio_io_ctrl
// Description : Directed self-checking bench for mmio_io_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_io_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata, rdata;
  logic [31:0] addr4, wdata4, rdata4;
  logic        wren, wren4, sel, sel4, irq, irq4;
  logic [15:0] in_raw, in_raw4, out_q, out_q4;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mmio_io_ctrl #(
    .BASE_ADDR(32'd4096), .IN_WIDTH(16), .OUT_WIDTH(16),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .wdata(wdata), .wren(wren),
    .rdata(rdata), .sel(sel), .in_raw(in_raw), .out_q(out_q), .irq(irq)
  );

  mmio_io_ctrl #(
    .BASE_ADDR(32'd4096), .IN_WIDTH(16), .OUT_WIDTH(16),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut4 (
    .clock(clock), .reset_n(reset_n), .addr(addr4), .wdata(wdata4), .wren(wren4),
    .rdata(rdata4), .sel(sel4), .in_raw(in_raw4), .out_q(out_q4), .irq(irq4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clock);
    #1 addr = a; wdata = d; wren = 1'b1;
    @(posedge clock);
    #1 wren = 1'b0; addr = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic bus_read4(input logic [31:0] a, output logic [31:0] d);
    addr4 = a;
    #1 d = rdata4;
  endtask

  initial begin
    reset_n = 1'b0; addr = '0; wdata = '0; wren = 1'b0; in_raw = 16'hFFFF;
    addr4 = '0; wdata4 = '0; wren4 = 1'b0; in_raw4 = 16'h0000;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_q", 32'(out_q), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    bus_read(32'd4096, rd);
    check("rst_in_data", rd, 32'h0);
    addr = 32'd4095; #1 check("sel_below", 32'(sel), 32'h0);
    addr = 32'd4102; #1 check("sel_above", 32'(sel), 32'h0);
    addr = 32'd4101; #1 check("sel_top", 32'(sel), 32'h1);
    addr = 32'd0; in_raw = 16'h0000;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);

    // Output writes
    bus_write(32'd4097, 32'h00F0);
    check("out_data", 32'(out_q), 32'h00F0);
    bus_write(32'd4098, 32'h0003);
    check("out_set", 32'(out_q), 32'h00F3);
    bus_write(32'd4099, 32'h0010);
    check("out_clr", 32'(out_q), 32'h00E3);
    bus_read(32'd4097, rd);
    check("rd_out_data", rd, 32'h0000_00E3);
    bus_read(32'd4098, rd);
    check("rd_out_set", rd, 32'h0);

    // Input path: change lands before edge 1, visible after edge 4
    @(posedge clock);
    #1 in_raw = 16'h0005; addr = 32'd4096;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clock);
      #1 check($sformatf("in_data_e%0d", e), rdata, (e < 4) ? 32'h0 : 32'h5);
    end
    bus_read(32'd4100, rd);
    check("in_chg", rd, 32'h5);
    check("irq_masked", 32'(irq), 32'h0);

    // Interrupt mask and W1C
    bus_write(32'd4101, 32'h4);
    check("irq_set", 32'(irq), 32'h1);
    bus_write(32'd4100, 32'h4);
    bus_read(32'd4100, rd);
    check("chg_w1c", rd, 32'h1);
    check("irq_clr", 32'(irq), 32'h0);

    // Bit 0 falls on deb at the same edge a W1C of bit 0 is sampled
    @(posedge clock);
    #1 in_raw = 16'h0004;
    repeat (3) @(posedge clock);
    #1 addr = 32'd4100; wdata = 32'h1; wren = 1'b1;
    @(posedge clock);
    #1 wren = 1'b0;
    bus_read(32'd4100, rd);
    check("chg_set_wins", rd, 32'h1);
    bus_read(32'd4096, rd);
    check("in_data_fall", rd, 32'h4);

    // Debounce filter on the DEBOUNCE_CYCLES=4 instance
    @(posedge clock);
    #1 in_raw4 = 16'h0001;
    repeat (3) @(posedge clock);
    #1 in_raw4 = 16'h0000;
    repeat (12) @(posedge clock);
    #1 bus_read4(32'd4096, rd);
    check("glitch_deb", rd, 32'h0);
    bus_read4(32'd4100, rd);
    check("glitch_chg", rd, 32'h0);
    @(posedge clock);
    #1 in_raw4 = 16'h0001;
    repeat (10) @(posedge clock);
    #1 bus_read4(32'd4096, rd);
    check("hold_deb", rd, 32'h1);
    repeat (2) @(posedge clock);
    #1 bus_read4(32'd4100, rd);
    check("hold_chg", rd, 32'h1);

    // Async reset mid-run
    bus_write(32'd4101, 32'h1);
    check("irq_pre_rst", 32'(irq), 32'h1);
    check("out_pre_rst", 32'(out_q), 32'h00E3);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("async_out_q", 32'(out_q), 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    bus_read(32'd4100, rd);
    check("async_chg", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Parametrised memory-mapped I/O controller between the processor's data-memory port and board switches/LEDs. It generalises the single fixed switch-read and LED-write decode to a relocatable register window. The window has configurable input and output widths and provides synchronised, debounced inputs, bit set/clear on outputs, sticky input-change flags and a maskable interrupt. The top level muxes `rdata` onto the processor's `q_dmem` whenever `sel` is high.

## Interface
- `BASE_ADDR`, 4096: word address of register offset 0.
- `IN_WIDTH`, 16: number of input bits (1..32).
- `OUT_WIDTH`, 16: number of output bits (1..32).
- `SYNC_STAGES`, 2: synchroniser flops per input bit (at least 2).
- `DEBOUNCE_CYCLES`, 50000: sample-tick period in clocks (at least 1).

- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `addr` in 32: processor data address.
- `wdata` in 32: processor store data.
- `wren` in 1: processor store strobe.
- `rdata` out 32: read data for the addressed register; 0 when `sel`=0.
- `sel` out 1: combinational, high when `addr` lies in the window.
- `in_raw` in IN_WIDTH: asynchronous board inputs (switches).
- `out_q` out OUT_WIDTH: registered board outputs (LEDs).
- `irq` out 1: level interrupt, `|(chg & mask)`.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - +0 `IN_DATA` (RO): debounced inputs.
  - +1 `OUT_DATA` (RW).
  - +2 `OUT_SET` (WO, write-1-sets).
  - +3 `OUT_CLR` (WO, write-1-clears).
  - +4 `IN_CHG` (RW1C).
  - +5 `IRQ_MASK` (RW).
- `sel` = (`addr` ≥ BASE_ADDR) && (`addr` ≤ BASE_ADDR+5). The comparison is unsigned over 32 bits.
- Reads are combinational from register state and have no side effects. Narrow fields are zero-extended to 32 bits. Write-only offsets read 0.
- Writes take effect on the rising edge where `wren` && `sel`. Only the low OUT_WIDTH or IN_WIDTH bits of `wdata` are used. Writes to `IN_DATA` are ignored.
- Input path, per bit: an SYNC_STAGES-deep synchroniser produces `sync`.
  - A shared prescaler counts 0..DEBOUNCE_CYCLES-1 and asserts `tick` when it equals DEBOUNCE_CYCLES-1, then wraps to 0.
  - On `tick`: `prev` ← `sync`; if `sync` == `prev` then `deb` ← `sync`.
  - `IN_DATA` = `deb`.
- On any edge where a `deb` bit changes, the corresponding `chg` bit is set.
- `chg` is cleared only by writing 1s to `IN_CHG`. If a set and a W1C clear hit the same bit on the same edge, the set wins.
- `irq` is combinational from the `chg` and `mask` registers.

## Timing
- Reset (asynchronous assert, synchronous use after deassert): the following all go to 0 immediately.
  - Registers and counters: `out_q`, `chg`, `mask`, `deb`, `prev`, the synchroniser chain and the prescaler.
  - Derived outputs: `irq` and `rdata`, as functions of the zeroed state.
- Store latency: `out_q` and all registers update on the same edge that samples the store, and are visible in the following cycle.
- Input latency with DEBOUNCE_CYCLES=1:
  - A stable change on `in_raw` before edge 1 appears on `sync` after edge SYNC_STAGES.
  - It appears on `deb` and `chg` after edge SYNC_STAGES+2.
- Input latency, general case: at most SYNC_STAGES + 2·DEBOUNCE_CYCLES edges.
- A glitch shorter than one tick period never reaches `deb`.
- Reset mid-debounce discards all pending samples. Inputs stable across reset deassertion are re-debounced from 0, so a set bit will raise `chg`.
- The prescaler runs continuously; it is unaffected by bus accesses.

## Structure
- Package `mmio_io_pkg` holds:
  - Offset constants `OFF_IN_DATA`..`OFF_IRQ_MASK` (0..5).
  - `NUM_REGS` = 6.
- Sub-module `io_debouncer`, parametrised by WIDTH, SYNC_STAGES and DEBOUNCE_CYCLES, contains the synchroniser chain, the prescaler and `prev`/`deb`.
  - It outputs `deb` and a one-cycle `deb_changed` vector.
  - Decode, registers and `irq` stay in `mmio_io_ctrl`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=1, SYNC_STAGES=2, BASE_ADDR=4096 unless noted.

- Reset values: hold `reset_n`=0 with `in_raw`=0xFFFF. Required response: `out_q`=0, `irq`=0, `IN_DATA` reads 0, and `sel`=0 at `addr`=4095 and at `addr`=4102.
- Output writes: store 0x00F0 to 4097, then 0x0003 to 4098, then 0x0010 to 4099. Required response: `out_q` is 0x00F0, then 0x00F3, then 0x00E3, each in the cycle after its store. Reading 4097 returns 0x000000E3 and reading 4098 returns 0.
- Input path: step `in_raw` 0x0000→0x0005 before edge 1. Required response: `IN_DATA`=0 through edge 3 and 0x5 after edge 4. `IN_CHG` reads 0x5.
- Interrupt: write 0x4 to 4101; `irq`=1. Write 0x4 to 4100; `IN_CHG`=0x1 and `irq`=0. A W1C of bit 0 on the same edge that bit 0 re-sets leaves bit 0 set.
- Debounce filter: with DEBOUNCE_CYCLES=4, pulse one `in_raw` bit high for 3 cycles. Required response: `deb` and `chg` are unchanged. Hold the bit for 12 cycles. Required response: `deb`=1 within 10 edges of the `sync` change.
- Async reset mid-run: assert `reset_n` low between edges. Required response: `out_q` clears before the next edge.
